// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared frame geometry and state encoding for serial bus masters
package bus_pkg;

  localparam int BUS_N      = 16;
  localparam int BUS_ADDR_W = 4;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_CRC_W  = 4;

  // START + src + dst + data + crc, then STOP
  localparam int SHIFT_LEN = 1 + 2 * BUS_ADDR_W + BUS_DATA_W + BUS_CRC_W;
  localparam int FRAME_LEN = SHIFT_LEN + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N      = BUS_N,
  parameter int ADDR_W = BUS_ADDR_W
) (
  input  logic [N-1:0]      req,
  input  logic [ADDR_W-1:0] ptr,
  output logic [N-1:0]      gnt,
  output logic [ADDR_W-1:0] idx,
  output logic              valid
);

  always_comb begin
    int c;
    c     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = ADDR_W'(c);
      end
    end
  end

endmodule

// File: rtl/serial_bus_scheduler.sv
// rtl/serial_bus_scheduler.sv - round-robin owner of the single-wire bus, shifts one 78-bit frame per grant
module serial_bus_scheduler
  import bus_pkg::*;
#(
  parameter int N      = BUS_N,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int CRC_W  = BUS_CRC_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          mod,
  input  logic [N*DATA_W-1:0]   data_flat,
  input  logic [N*ADDR_W-1:0]   addr_flat,
  input  logic [N*CRC_W-1:0]    crc_flat,
  output logic                  bus_out,
  output logic                  busy,
  output logic [N-1:0]          grant,
  output logic [N-1:0]          done
);

  localparam int SL = 1 + 2 * ADDR_W + DATA_W + CRC_W;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rr_ptr;
  logic [6:0]        bit_cnt;
  // bus_out already carries the current bit, so only the remaining SL-1 bits are held here
  logic [SL-2:0]     shift_reg;

  logic [N-1:0]      arb_gnt;
  logic [ADDR_W-1:0] arb_idx;
  logic              arb_valid;
  logic [SL-1:0]     frame;

  rr_arbiter #(.N(N), .ADDR_W(ADDR_W)) u_arb (
    .req   (mod),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign frame = {1'b0, arb_idx,
                  addr_flat[int'(arb_idx)*ADDR_W +: ADDR_W],
                  data_flat[int'(arb_idx)*DATA_W +: DATA_W],
                  crc_flat[int'(arb_idx)*CRC_W +: CRC_W]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= ADDR_W'(N - 1);
      bit_cnt   <= '0;
      shift_reg <= '0;
      bus_out   <= 1'b1;
      busy      <= 1'b0;
      grant     <= '0;
      done      <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus_out <= 1'b1;
          done    <= '0;
          if (arb_valid) begin
            bus_out   <= frame[SL-1];
            shift_reg <= frame[SL-2:0];
            grant     <= arb_gnt;
            rr_ptr    <= arb_idx;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == 7'(SL - 1)) begin
            bus_out <= 1'b1;
            done    <= grant;
            state   <= STOP;
          end else begin
            bus_out   <= shift_reg[SL-2];
            shift_reg <= {shift_reg[SL-3:0], 1'b0};
            bit_cnt   <= bit_cnt + 7'd1;
          end
        end
        STOP: begin
          bus_out <= 1'b1;
          done    <= '0;
          grant   <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
